sc_match_scorer: RTL and testbench

Consumer end of the serialized match stream produced by the scoring-buffer serializer.
- Takes one (match_en, match_dt) event per cycle, plus a separate missed-note strobe.
- Grades each hit against timing windows, then maintains score, streak, multiplier and miss count.
- Sits between the serializer and the display/HUD logic in the Nexys4 game datapath.

---
 rtl/sc_pkg.sv | 32 +++
 rtl/sc_grade_lut.sv | 32 +++
 rtl/sc_match_scorer.sv | 125 ++++++++++++
 tb/tb_sc_match_scorer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared constants for the match scorer and the HUD: grade encodings, default
// timing windows and points, and the streak-to-multiplier thresholds.
package sc_pkg;

  localparam logic [1:0] GRADE_BAD     = 2'd0;
  localparam logic [1:0] GRADE_OK      = 2'd1;
  localparam logic [1:0] GRADE_GOOD    = 2'd2;
  localparam logic [1:0] GRADE_PERFECT = 2'd3;

  localparam int PERFECT_WIN_DEF = 2;
  localparam int GOOD_WIN_DEF    = 5;
  localparam int OK_WIN_DEF      = 10;

  localparam int PTS_PERFECT_DEF = 100;
  localparam int PTS_GOOD_DEF    = 50;
  localparam int PTS_OK_DEF      = 20;
  localparam int PTS_W           = 8;

  localparam int unsigned MULT_T1  = 10;
  localparam int unsigned MULT_T2  = 20;
  localparam int unsigned MULT_T3  = 30;
  localparam int unsigned MULT_MAX = 4;

  // Threshold compares instead of streak/10, so no divider is inferred.
  function automatic logic [2:0] mult_for(input int unsigned s);
    if (s < MULT_T1)      return 3'd1;
    else if (s < MULT_T2) return 3'd2;
    else if (s < MULT_T3) return 3'd3;
    else                  return 3'(MULT_MAX);
  endfunction

endpackage

// File: rtl/sc_grade_lut.sv
// Combinational mapping from absolute timing error to grade and base points.
module sc_grade_lut
  import sc_pkg::*;
#(
  parameter int PERFECT_WIN = PERFECT_WIN_DEF,
  parameter int GOOD_WIN    = GOOD_WIN_DEF,
  parameter int OK_WIN      = OK_WIN_DEF,
  parameter int PTS_PERFECT = PTS_PERFECT_DEF,
  parameter int PTS_GOOD    = PTS_GOOD_DEF,
  parameter int PTS_OK      = PTS_OK_DEF
) (
  input  logic [15:0]      dt_i,
  output logic [1:0]       grade_o,
  output logic [PTS_W-1:0] pts_o
);

  always_comb begin
    grade_o = GRADE_BAD;
    pts_o   = '0;
    if (dt_i <= 16'(PERFECT_WIN)) begin
      grade_o = GRADE_PERFECT;
      pts_o   = PTS_W'(PTS_PERFECT);
    end else if (dt_i <= 16'(GOOD_WIN)) begin
      grade_o = GRADE_GOOD;
      pts_o   = PTS_W'(PTS_GOOD);
    end else if (dt_i <= 16'(OK_WIN)) begin
      grade_o = GRADE_OK;
      pts_o   = PTS_W'(PTS_OK);
    end
  end

endmodule

// File: rtl/sc_match_scorer.sv
// Two-stage scorer: stage 1 grades each hit, stage 2 updates score, streak,
// multiplier and miss count with saturating arithmetic.
module sc_match_scorer
  import sc_pkg::*;
#(
  parameter int PERFECT_WIN = PERFECT_WIN_DEF,
  parameter int GOOD_WIN    = GOOD_WIN_DEF,
  parameter int OK_WIN      = OK_WIN_DEF,
  parameter int PTS_PERFECT = PTS_PERFECT_DEF,
  parameter int PTS_GOOD    = PTS_GOOD_DEF,
  parameter int PTS_OK      = PTS_OK_DEF,
  parameter int SCORE_W     = 24,
  parameter int STREAK_W    = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                match_en,
  input  logic [15:0]         match_dt,
  input  logic                miss_en,
  output logic                grade_valid,
  output logic [1:0]          grade,
  output logic [SCORE_W-1:0]  score,
  output logic [STREAK_W-1:0] streak,
  output logic [2:0]          multiplier,
  output logic [STREAK_W-1:0] miss_count
);

  localparam int SUM_W  = SCORE_W + 1;
  localparam int PROD_W = (PTS_W + 3 > SUM_W) ? PTS_W + 3 : SUM_W;

  logic [1:0]       lut_grade;
  logic [PTS_W-1:0] lut_pts;

  logic             s1_valid_q;
  logic [1:0]       s1_grade_q;
  logic [PTS_W-1:0] s1_pts_q;
  logic             s1_miss_q;

  logic [SCORE_W-1:0]  score_q, score_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [STREAK_W-1:0] miss_q, miss_d;
  logic [2:0]          mult_q, mult_d;

  logic              hit_ok, hit_bad;
  logic [1:0]        miss_inc;
  logic [PROD_W-1:0] prod_full;
  logic [SUM_W-1:0]  prod, sum;
  logic [STREAK_W:0] miss_sum;

  sc_grade_lut #(
    .PERFECT_WIN (PERFECT_WIN),
    .GOOD_WIN    (GOOD_WIN),
    .OK_WIN      (OK_WIN),
    .PTS_PERFECT (PTS_PERFECT),
    .PTS_GOOD    (PTS_GOOD),
    .PTS_OK      (PTS_OK)
  ) u_lut (
    .dt_i    (match_dt),
    .grade_o (lut_grade),
    .pts_o   (lut_pts)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_grade_q <= GRADE_BAD;
      s1_pts_q   <= '0;
      s1_miss_q  <= 1'b0;
    end else begin
      s1_valid_q <= match_en;
      s1_miss_q  <= miss_en;
      if (match_en) begin
        s1_grade_q <= lut_grade;
        s1_pts_q   <= lut_pts;
      end
    end
  end

  // A miss landing in the same cycle as a good hit still pays the hit at the
  // pre-update multiplier, but the streak is cleared afterwards.
  always_comb begin
    hit_ok    = s1_valid_q && (s1_grade_q != GRADE_BAD);
    hit_bad   = s1_valid_q && (s1_grade_q == GRADE_BAD);
    miss_inc  = 2'(hit_bad) + 2'(s1_miss_q);

    prod_full = PROD_W'(s1_pts_q) * PROD_W'(mult_q);
    if (prod_full > PROD_W'({SCORE_W{1'b1}})) prod = SUM_W'({SCORE_W{1'b1}});
    else                                     prod = SUM_W'(prod_full);
    sum = SUM_W'(score_q) + prod;

    score_d = score_q;
    if (hit_ok) score_d = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];

    streak_d = streak_q;
    if (hit_ok && (streak_q != {STREAK_W{1'b1}})) streak_d = streak_q + STREAK_W'(1);
    if (hit_bad || s1_miss_q) streak_d = '0;

    miss_sum = {1'b0, miss_q} + (STREAK_W + 1)'(miss_inc);
    miss_d   = miss_sum[STREAK_W] ? {STREAK_W{1'b1}} : miss_sum[STREAK_W-1:0];

    mult_d = mult_for(32'(streak_d));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      score_q  <= '0;
      streak_q <= '0;
      miss_q   <= '0;
      mult_q   <= 3'd1;
    end else begin
      score_q  <= score_d;
      streak_q <= streak_d;
      miss_q   <= miss_d;
      mult_q   <= mult_d;
    end
  end

  assign grade_valid = s1_valid_q;
  assign grade       = s1_grade_q;
  assign score       = score_q;
  assign streak      = streak_q;
  assign multiplier  = mult_q;
  assign miss_count  = miss_q;

endmodule

// File: tb/tb_sc_match_scorer.sv
// Directed self-checking bench for sc_match_scorer, with a second narrow-score
// instance used to exercise score saturation.
module tb_sc_match_scorer;

  logic        clk = 1'b0;
  logic        reset;
  logic        match_en, miss_en;
  logic [15:0] match_dt;
  logic        grade_valid;
  logic [1:0]  grade;
  logic [23:0] score;
  logic [9:0]  streak;
  logic [2:0]  multiplier;
  logic [9:0]  miss_count;

  logic        m8_en, m8_miss;
  logic [15:0] m8_dt;
  logic        g8_valid;
  logic [1:0]  g8_grade;
  logic [7:0]  g8_score;
  logic [9:0]  g8_streak;
  logic [2:0]  g8_mult;
  logic [9:0]  g8_missc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sc_match_scorer dut (
    .clk(clk), .reset(reset), .match_en(match_en), .match_dt(match_dt),
    .miss_en(miss_en), .grade_valid(grade_valid), .grade(grade), .score(score),
    .streak(streak), .multiplier(multiplier), .miss_count(miss_count)
  );

  sc_match_scorer #(.SCORE_W(8)) dut8 (
    .clk(clk), .reset(reset), .match_en(m8_en), .match_dt(m8_dt),
    .miss_en(m8_miss), .grade_valid(g8_valid), .grade(g8_grade), .score(g8_score),
    .streak(g8_streak), .multiplier(g8_mult), .miss_count(g8_missc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (grade_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle_gv cycle %0d got %b want 0", i, grade_valid);
      end
    end
    checks++;
    if (score !== 24'd0) begin failures++; $display("FAIL reset_score got %0d want 0", score); end
    checks++;
    if (streak !== 10'd0) begin failures++; $display("FAIL reset_streak got %0d want 0", streak); end
    checks++;
    if (multiplier !== 3'd1) begin failures++; $display("FAIL reset_mult got %0d want 1", multiplier); end
    checks++;
    if (miss_count !== 10'd0) begin failures++; $display("FAIL reset_miss got %0d want 0", miss_count); end
    checks++;
    if (g8_score !== 8'd0) begin failures++; $display("FAIL reset_score8 got %0d want 0", g8_score); end
  endtask

  task automatic test_grading();
    int dts[6]    = '{2, 3, 5, 10, 6, 11};
    int grades[6] = '{3, 2, 2, 1, 1, 0};
    int scores[6] = '{100, 150, 200, 220, 240, 240};
    int strks[6]  = '{1, 2, 3, 4, 5, 0};
    int misses[6] = '{0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 6; i++) begin
      match_en = 1'b1;
      match_dt = 16'(dts[i]);
      tick();
      match_en = 1'b0;
      checks++;
      if (grade_valid !== 1'b1) begin failures++; $display("FAIL grade_valid dt=%0d got %b want 1", dts[i], grade_valid); end
      checks++;
      if (grade !== 2'(grades[i])) begin failures++; $display("FAIL grade dt=%0d got %0d want %0d", dts[i], grade, grades[i]); end
      tick();
      checks++;
      if (grade_valid !== 1'b0) begin failures++; $display("FAIL grade_pulse dt=%0d got %b want 0", dts[i], grade_valid); end
      checks++;
      if (score !== 24'(scores[i])) begin failures++; $display("FAIL score dt=%0d got %0d want %0d", dts[i], score, scores[i]); end
      checks++;
      if (streak !== 10'(strks[i])) begin failures++; $display("FAIL streak dt=%0d got %0d want %0d", dts[i], streak, strks[i]); end
      checks++;
      if (multiplier !== 3'd1) begin failures++; $display("FAIL mult dt=%0d got %0d want 1", dts[i], multiplier); end
      checks++;
      if (miss_count !== 10'(misses[i])) begin failures++; $display("FAIL miss dt=%0d got %0d want %0d", dts[i], miss_count, misses[i]); end
    end
  endtask

  task automatic test_miss_only();
    miss_en = 1'b1;
    tick();
    miss_en = 1'b0;
    checks++;
    if (grade_valid !== 1'b0) begin failures++; $display("FAIL miss_no_gv got %b want 0", grade_valid); end
    checks++;
    if (miss_count !== 10'd1) begin failures++; $display("FAIL miss_latency got %0d want 1", miss_count); end
    tick();
    checks++;
    if (miss_count !== 10'd2) begin failures++; $display("FAIL miss_count got %0d want 2", miss_count); end
    checks++;
    if (score !== 24'd240) begin failures++; $display("FAIL miss_score got %0d want 240", score); end
  endtask

  task automatic test_back_to_back();
    int bursts[4] = '{10, 1, 19, 10};
    int scores[4] = '{1000, 1200, 6000, 10000};
    int strks[4]  = '{10, 11, 30, 40};
    int mults[4]  = '{2, 2, 4, 4};
    do_reset();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < bursts[b]; i++) begin
        match_en = 1'b1;
        match_dt = 16'd0;
        tick();
        checks++;
        if (grade_valid !== 1'b1) begin failures++; $display("FAIL b2b_gv burst %0d hit %0d got %b want 1", b, i, grade_valid); end
      end
      match_en = 1'b0;
      tick();
      checks++;
      if (score !== 24'(scores[b])) begin failures++; $display("FAIL b2b_score burst %0d got %0d want %0d", b, score, scores[b]); end
      checks++;
      if (streak !== 10'(strks[b])) begin failures++; $display("FAIL b2b_streak burst %0d got %0d want %0d", b, streak, strks[b]); end
      checks++;
      if (multiplier !== 3'(mults[b])) begin failures++; $display("FAIL b2b_mult burst %0d got %0d want %0d", b, multiplier, mults[b]); end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    match_en = 1'b1;
    match_dt = 16'd0;
    repeat (10) tick();
    match_en = 1'b0;
    tick();
    // Hit and miss in the same cycle while multiplier is 2.
    match_en = 1'b1;
    miss_en  = 1'b1;
    tick();
    match_en = 1'b0;
    miss_en  = 1'b0;
    checks++;
    if (grade !== 2'd3) begin failures++; $display("FAIL sim_grade got %0d want 3", grade); end
    tick();
    checks++;
    if (score !== 24'd1200) begin failures++; $display("FAIL sim_score got %0d want 1200", score); end
    checks++;
    if (streak !== 10'd0) begin failures++; $display("FAIL sim_streak got %0d want 0", streak); end
    checks++;
    if (multiplier !== 3'd1) begin failures++; $display("FAIL sim_mult got %0d want 1", multiplier); end
    checks++;
    if (miss_count !== 10'd1) begin failures++; $display("FAIL sim_miss got %0d want 1", miss_count); end
    // Hit then a miss one cycle later.
    match_en = 1'b1;
    tick();
    match_en = 1'b0;
    miss_en  = 1'b1;
    tick();
    miss_en  = 1'b0;
    checks++;
    if (score !== 24'd1300) begin failures++; $display("FAIL stag_score got %0d want 1300", score); end
    checks++;
    if (streak !== 10'd1) begin failures++; $display("FAIL stag_streak1 got %0d want 1", streak); end
    tick();
    checks++;
    if (streak !== 10'd0) begin failures++; $display("FAIL stag_streak0 got %0d want 0", streak); end
    checks++;
    if (miss_count !== 10'd2) begin failures++; $display("FAIL stag_miss got %0d want 2", miss_count); end
    // BAD hit together with a miss counts twice.
    match_en = 1'b1;
    match_dt = 16'd20;
    miss_en  = 1'b1;
    tick();
    match_en = 1'b0;
    miss_en  = 1'b0;
    checks++;
    if (grade !== 2'd0) begin failures++; $display("FAIL bad_grade got %0d want 0", grade); end
    tick();
    checks++;
    if (miss_count !== 10'd4) begin failures++; $display("FAIL bad_miss got %0d want 4", miss_count); end
    checks++;
    if (score !== 24'd1300) begin failures++; $display("FAIL bad_score got %0d want 1300", score); end
  endtask

  task automatic test_saturation();
    int exp[4] = '{100, 200, 255, 255};
    for (int i = 0; i < 4; i++) begin
      m8_en = 1'b1;
      m8_dt = 16'd0;
      tick();
      m8_en = 1'b0;
      tick();
      checks++;
      if (g8_score !== 8'(exp[i])) begin failures++; $display("FAIL sat_score hit %0d got %0d want %0d", i, g8_score, exp[i]); end
    end
  endtask

  task automatic test_reset_midflight();
    match_en = 1'b1;
    match_dt = 16'd0;
    tick();
    match_en = 1'b0;
    reset    = 1'b1;
    tick();
    checks++;
    if (grade_valid !== 1'b0) begin failures++; $display("FAIL mid_gv got %b want 0", grade_valid); end
    checks++;
    if (grade !== 2'd0) begin failures++; $display("FAIL mid_grade got %0d want 0", grade); end
    checks++;
    if (score !== 24'd0) begin failures++; $display("FAIL mid_score got %0d want 0", score); end
    checks++;
    if (streak !== 10'd0) begin failures++; $display("FAIL mid_streak got %0d want 0", streak); end
    checks++;
    if (multiplier !== 3'd1) begin failures++; $display("FAIL mid_mult got %0d want 1", multiplier); end
    checks++;
    if (miss_count !== 10'd0) begin failures++; $display("FAIL mid_miss got %0d want 0", miss_count); end
    reset = 1'b0;
    tick();
    checks++;
    if (grade_valid !== 1'b0) begin failures++; $display("FAIL mid_after_gv got %b want 0", grade_valid); end
    checks++;
    if (score !== 24'd0) begin failures++; $display("FAIL mid_after_score got %0d want 0", score); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    match_en = 1'b0;
    match_dt = 16'd0;
    miss_en  = 1'b0;
    m8_en    = 1'b0;
    m8_dt    = 16'd0;
    m8_miss  = 1'b0;
    $display("[TB] starting sc_match_scorer bench");
    test_reset();
    test_grading();
    test_miss_only();
    test_back_to_back();
    test_simultaneous();
    test_saturation();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
